i2c_target_fifo: RTL and testbench
==================================

Name: i2c_target_fifo

Overview:
- Downstream neighbour of the I2C master controller: an I2C target (slave) that consumes that master's SCL and SDA and answers on the shared line.
- Master write transfer (addr + 1 data byte): the data byte is pushed into an RX FIFO, which local logic drains.
- Master read transfer: the target returns a byte from a TX holding register loaded by local logic.
- Used on-chip as the loopback/bring-up partner for the master and as the target side of the multi-protocol module.

Parameters:
- TARGET_ADDR, 7'h50, 7-bit address this target acknowledges.
- FIFO_DEPTH, 8, RX FIFO entries (power of two, 2..64).
- IDLE_BYTE, 8'hFF, byte returned on a master read when the TX register is empty.
- FILTER_LEN, 3, stability length in clk cycles for the optional glitch filter.

Ports:
- clk  in  1  system clock (same domain as the master).
- rst  in  1  asynchronous, active-low reset.
- scl  in  1  bus clock from the master.
- sda_in  in  1  resolved SDA line: master drive when enabled, else this target's drive, else pull-up 1.
- sda_out  out  1  value this target drives; always 0 when sda_en=1.
- sda_en  out  1  target drives SDA low when 1, otherwise releases.
- rx_rd  in  1  pop strobe for the RX FIFO; ignored when rx_empty.
- rx_data  out  8  RX FIFO head (first-word fall-through).
- rx_empty  out  1  RX FIFO empty.
- rx_full  out  1  RX FIFO full.
- rx_level  out  $clog2(FIFO_DEPTH)+1  RX occupancy.
- tx_load  in  1  load tx_data into the TX holding register.
- tx_data  in  8  byte for the next master read.
- tx_valid  out  1  TX holding register holds an unread byte.
- busy  out  1  high from a matching address ACK until STOP.
- addr_nack  out  1  one-cycle pulse on a START whose address mismatches.
- ovf  out  1  sticky; set when a write arrives with the FIFO full; cleared by reset only.

Behaviour:
- Reset values: sda_en=0, sda_out=1, rx_empty=1, rx_full=0, rx_level=0, rx_data=0, tx_valid=0, busy=0, addr_nack=0, ovf=0. FSM goes to IDLE.
- Synchronisation: scl and sda_in pass through 2-flop synchronisers. Edges are detected on the synchronised copies; total input latency is 2 clk.
- START: sda falls while scl=1. It is recognised in any state, including a repeated START, and resets the bit counter and moves the FSM to ADDR.
- STOP: sda rises while scl=1. From any state it goes to IDLE, releases SDA and clears busy.
- Bit timing: bits are sampled on the scl rising edge (MSB first). The target changes its SDA drive only on the cycle after a scl falling edge.
- ADDR: shift 8 bits (7 address + R/W).
  - Match → ADDR_ACK: drive SDA low from the falling edge after bit 8 to the falling edge after bit 9; busy=1.
  - Mismatch → pulse addr_nack, keep SDA released, go to WAIT_STOP.
- After ADDR_ACK: R/W=0 → WR_DATA; R/W=1 → RD_DATA.
- WR_DATA: shift 8 bits, then WR_ACK.
  - Not full: push the byte, drive ACK low.
  - Full: do not push, release SDA (NACK), set ovf.
  - Next state: WAIT_STOP.
- RD_DATA:
  - Entry: latch the byte to send — the TX register if tx_valid, else IDLE_BYTE. tx_valid clears at this latch.
  - Bit 7 is driven on the falling edge ending the ACK bit; each following bit on the next falling edge. A 0 bit → sda_en=1; a 1 bit → sda_en=0.
  - After 8 bits, release SDA and go to RD_ACK.
- RD_ACK: sample the master ACK on the rising edge. ACK (0) or NACK (1) both go to WAIT_STOP, since a single-byte read is the only supported transfer.
- WAIT_STOP: SDA released; wait for STOP or START.
- RX FIFO:
  - Circular buffer; pointers are one bit wider than the index so full and empty are distinguishable. Wrap is at FIFO_DEPTH.
  - A push and rx_rd in the same cycle: level unchanged; a push on full is impossible in that case because the pop frees space first.
  - rx_rd on empty: no effect.
- tx_load in the same cycle as the RD_DATA latch: the latch takes the old register contents; the new byte is stored and tx_valid stays 1.
- Reset mid-transfer: SDA is released immediately (asynchronous). FIFO contents are discarded.

Optional Feature:
- Macro: I2C_TARGET_GLITCH_FILTER_EN.
- Defined: after synchronisation, scl and sda each pass through a filter. The filtered value updates only after the raw value has been stable for FILTER_LEN consecutive clk cycles, which adds FILTER_LEN cycles of latency. Pulses shorter than FILTER_LEN are rejected.
- Undefined: no filter; only the 2-flop synchroniser is present.

Test Plan:
- Reset, then master write addr 0x50, data 0xA5 → ACK on both bytes; rx_level=1; rx_data=0xA5; busy falls at STOP; ack_err=0 at the master.
- Master write to addr 0x51 → SDA never driven by the target; addr_nack pulses once; master ack_err=1; FIFO unchanged.
- 8 writes of 0x00..0x07, then a 9th write of 0xEE → the 9th data byte is NACKed and ovf=1; popping 8 times returns 0x00..0x07 in order; rx_empty=1 afterwards.
- tx_load 0x3C, then master read of 0x50 → master dat_out=0x3C; tx_valid returns to 0; a second read returns 0xFF.
- rx_rd asserted in the same cycle as the WR_ACK push with level=3 → level stays 3; the head advances correctly.
- Active-low reset asserted while the target drives ACK low → sda_en=0 within the same cycle; all outputs return to reset values; the next transfer completes normally.

Source files
------------

// File: rtl/i2c_target_fifo.sv
// rtl/i2c_target_fifo.sv - I2C target: write bytes land in an RX FIFO, reads return a TX holding register
// Optional SCL/SDA glitch filter is enabled by defining I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target_fifo #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         FIFO_DEPTH  = 8,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF,
  parameter int         FILTER_LEN  = 3
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_scl,
  input  logic                          i_sda_in,
  output logic                          o_sda_out,
  output logic                          o_sda_en,
  input  logic                          i_rx_rd,
  output logic [7:0]                    o_rx_data,
  output logic                          o_rx_empty,
  output logic                          o_rx_full,
  output logic [$clog2(FIFO_DEPTH):0]   o_rx_level,
  input  logic                          i_tx_load,
  input  logic [7:0]                    i_tx_data,
  output logic                          o_tx_valid,
  output logic                          o_busy,
  output logic                          o_addr_nack,
  output logic                          o_ovf
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_WAIT_STOP
  } state_t;

  logic r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
  logic r_scl_q, r_sda_q;
  logic w_scl, w_sda;
  logic w_scl_rise, w_scl_fall, w_start, w_stop;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
    end else begin
      r_scl_s1 <= i_scl;
      r_scl_s2 <= r_scl_s1;
      r_sda_s1 <= i_sda_in;
      r_sda_s2 <= r_sda_s1;
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] FL_LAST = CW'(FILTER_LEN - 1);
  logic [CW-1:0] r_scl_cnt, r_sda_cnt;
  logic          r_scl_f, r_sda_f;

  // A differing raw value must persist FILTER_LEN cycles before it is accepted.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_scl_cnt <= '0;
      r_sda_cnt <= '0;
      r_scl_f   <= 1'b1;
      r_sda_f   <= 1'b1;
    end else begin
      if (r_scl_s2 == r_scl_f) begin
        r_scl_cnt <= '0;
      end else if (r_scl_cnt == FL_LAST) begin
        r_scl_f   <= r_scl_s2;
        r_scl_cnt <= '0;
      end else begin
        r_scl_cnt <= r_scl_cnt + 1'b1;
      end
      if (r_sda_s2 == r_sda_f) begin
        r_sda_cnt <= '0;
      end else if (r_sda_cnt == FL_LAST) begin
        r_sda_f   <= r_sda_s2;
        r_sda_cnt <= '0;
      end else begin
        r_sda_cnt <= r_sda_cnt + 1'b1;
      end
    end
  end

  assign w_scl = r_scl_f;
  assign w_sda = r_sda_f;
`else
  assign w_scl = r_scl_s2;
  assign w_sda = r_sda_s2;
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_scl_q <= 1'b1;
      r_sda_q <= 1'b1;
    end else begin
      r_scl_q <= w_scl;
      r_sda_q <= w_sda;
    end
  end

  assign w_scl_rise = w_scl & ~r_scl_q;
  assign w_scl_fall = ~w_scl & r_scl_q;
  assign w_start    = w_scl & r_scl_q & r_sda_q & ~w_sda;
  assign w_stop     = w_scl & r_scl_q & ~r_sda_q & w_sda;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_bit_cnt;
  logic [7:0]    r_shift, r_tx_shift, r_tx_reg;
  logic          r_rw, r_sda_en, r_busy, r_addr_nack, r_ovf, r_tx_valid;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr, r_rd_ptr;
  logic          w_empty, w_full, w_pop, w_can_push, w_addr_match;
  logic [7:0]    w_rd_byte;
  logic          w_sda_en_nxt, w_push, w_ovf_set, w_latch, w_nack, w_busy_set;

  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop        = i_rx_rd & ~w_empty;
  assign w_can_push   = ~w_full | w_pop;
  assign w_addr_match = (r_shift[6:0] == TARGET_ADDR);
  assign w_rd_byte    = r_tx_valid ? r_tx_reg : IDLE_BYTE;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_stop) begin
      w_state_nxt = S_IDLE;
    end else if (w_start) begin
      w_state_nxt = S_ADDR;
    end else begin
      case (r_state)
        S_ADDR:     if (w_scl_rise && r_bit_cnt == 4'd7)
                      w_state_nxt = w_addr_match ? S_ADDR_ACK : S_WAIT_STOP;
        S_ADDR_ACK: if (w_scl_fall && r_bit_cnt == 4'd2)
                      w_state_nxt = r_rw ? S_RD_DATA : S_WR_DATA;
        S_WR_DATA:  if (w_scl_rise && r_bit_cnt == 4'd7) w_state_nxt = S_WR_ACK;
        S_WR_ACK:   if (w_scl_fall && r_bit_cnt == 4'd2) w_state_nxt = S_WAIT_STOP;
        S_RD_DATA:  if (w_scl_fall && r_bit_cnt == 4'd8) w_state_nxt = S_RD_ACK;
        S_RD_ACK:   if (w_scl_rise) w_state_nxt = S_WAIT_STOP;
        default:    w_state_nxt = r_state;
      endcase
    end
  end

  // Ack phases use r_bit_cnt as 0 = before drive, 1 = driving, 2 = ack bit clocked.
  always_comb begin
    w_sda_en_nxt = r_sda_en;
    w_push       = 1'b0;
    w_ovf_set    = 1'b0;
    w_latch      = 1'b0;
    w_nack       = 1'b0;
    w_busy_set   = 1'b0;
    if (w_start || w_stop) begin
      w_sda_en_nxt = 1'b0;
    end else begin
      case (r_state)
        S_ADDR: begin
          w_sda_en_nxt = 1'b0;
          w_nack       = w_scl_rise && (r_bit_cnt == 4'd7) && !w_addr_match;
        end
        S_ADDR_ACK: if (w_scl_fall) begin
          if (r_bit_cnt == 4'd0) begin
            w_sda_en_nxt = 1'b1;
            w_busy_set   = 1'b1;
          end else if (r_bit_cnt == 4'd2) begin
            w_latch      = r_rw;
            w_sda_en_nxt = r_rw & ~w_rd_byte[7];
          end
        end
        S_WR_ACK: if (w_scl_fall) begin
          if (r_bit_cnt == 4'd0) begin
            w_push       = w_can_push;
            w_ovf_set    = ~w_can_push;
            w_sda_en_nxt = w_can_push;
          end else if (r_bit_cnt == 4'd2) begin
            w_sda_en_nxt = 1'b0;
          end
        end
        S_RD_DATA: if (w_scl_fall) begin
          w_sda_en_nxt = (r_bit_cnt == 4'd8) ? 1'b0 : ~r_tx_shift[7];
        end
        default: w_sda_en_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_tx_shift  <= '0;
      r_rw        <= 1'b0;
      r_sda_en    <= 1'b0;
      r_busy      <= 1'b0;
      r_addr_nack <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_sda_en    <= w_sda_en_nxt;
      r_addr_nack <= w_nack;
      if (w_ovf_set) r_ovf <= 1'b1;
      if (w_stop) r_busy <= 1'b0;
      else if (w_busy_set) r_busy <= 1'b1;
      if (w_start || w_stop) begin
        r_bit_cnt <= '0;
      end else begin
        case (r_state)
          S_ADDR, S_WR_DATA: if (w_scl_rise) begin
            r_shift   <= {r_shift[6:0], w_sda};
            r_bit_cnt <= (r_bit_cnt == 4'd7) ? 4'd0 : r_bit_cnt + 4'd1;
            if (r_state == S_ADDR && r_bit_cnt == 4'd7) r_rw <= w_sda;
          end
          S_ADDR_ACK, S_WR_ACK: begin
            if (w_scl_fall && r_bit_cnt == 4'd0)      r_bit_cnt <= 4'd1;
            else if (w_scl_rise && r_bit_cnt == 4'd1) r_bit_cnt <= 4'd2;
            else if (w_scl_fall && r_bit_cnt == 4'd2) r_bit_cnt <= 4'd0;
          end
          S_RD_DATA: if (w_scl_fall) begin
            r_bit_cnt  <= (r_bit_cnt == 4'd8) ? 4'd0 : r_bit_cnt + 4'd1;
            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
          end
          default: r_bit_cnt <= r_bit_cnt;
        endcase
        if (w_latch) begin
          r_tx_shift <= {w_rd_byte[6:0], 1'b0};
          r_bit_cnt  <= 4'd1;
        end
      end
    end
  end

  // A load coinciding with the read latch keeps the new byte pending.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_tx_reg   <= '0;
      r_tx_valid <= 1'b0;
    end else if (i_tx_load) begin
      r_tx_reg   <= i_tx_data;
      r_tx_valid <= 1'b1;
    end else if (w_latch) begin
      r_tx_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
  end

  assign o_sda_en    = r_sda_en;
  assign o_sda_out   = ~r_sda_en;
  assign o_rx_data   = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_rx_empty  = w_empty;
  assign o_rx_full   = w_full;
  assign o_rx_level  = r_wr_ptr - r_rd_ptr;
  assign o_tx_valid  = r_tx_valid;
  assign o_busy      = r_busy;
  assign o_addr_nack = r_addr_nack;
  assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_i2c_target_fifo.sv
// tb/tb_i2c_target_fifo.sv - bit-banged I2C master driving i2c_target_fifo against a queue model
module tb_i2c_target_fifo;
  localparam int Q = 8;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic       rx_rd = 1'b0;
  logic       tx_load = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       sda_line, sda_out, sda_en, rx_empty, rx_full, tx_valid, busy, addr_nack, ovf;
  logic [7:0] rx_data;
  logic [3:0] rx_level;

  int n_tests = 0;
  int n_fail  = 0;
  int drive_cnt = 0;
  int nack_cnt  = 0;

  logic [7:0] model_q[$];
  logic       model_ovf = 1'b0;
  logic       model_txv = 1'b0;
  logic [7:0] model_tx  = 8'h00;

  assign sda_line = ~(m_low | sda_en);

  i2c_target_fifo dut (
    .i_clk(clk), .i_rst(rst_n), .i_scl(scl), .i_sda_in(sda_line),
    .o_sda_out(sda_out), .o_sda_en(sda_en), .i_rx_rd(rx_rd), .o_rx_data(rx_data),
    .o_rx_empty(rx_empty), .o_rx_full(rx_full), .o_rx_level(rx_level),
    .i_tx_load(tx_load), .i_tx_data(tx_data), .o_tx_valid(tx_valid),
    .o_busy(busy), .o_addr_nack(addr_nack), .o_ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sda_en) drive_cnt++;
    if (addr_nack) nack_cnt++;
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period; optional rx_rd pulse lands on the clock that sees this bit's falling edge.
  task automatic m_bit(input logic b, input bit pop, output logic r);
    m_low = ~b;
    wait_n(Q);
    scl = 1'b1;
    wait_n(Q);
    r = sda_line;
    wait_n(Q);
    scl = 1'b0;
    if (pop) begin
      wait_n(LAT);
      rx_rd = 1'b1;
      wait_n(1);
      rx_rd = 1'b0;
      wait_n(Q - LAT - 1);
    end else begin
      wait_n(Q);
    end
  endtask

  task automatic m_start();
    m_low = 1'b0;
    wait_n(Q);
    m_low = 1'b1;
    wait_n(Q);
    scl = 1'b0;
    wait_n(Q);
  endtask

  task automatic m_stop();
    m_low = 1'b1;
    wait_n(Q);
    scl = 1'b1;
    wait_n(Q);
    m_low = 1'b0;
    wait_n(2 * Q);
  endtask

  task automatic m_write_byte(input logic [7:0] d, input bit pop, output bit ack);
    logic r;
    for (int i = 7; i >= 0; i--) m_bit(d[i], pop && (i == 0), r);
    m_bit(1'b1, 1'b0, r);
    ack = (r == 1'b0);
  endtask

  task automatic m_read_byte(output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, 1'b0, r);
      d[i] = r;
    end
    m_bit(1'b1, 1'b0, r);
  endtask

  task automatic m_write(input logic [6:0] addr, input logic [7:0] data, input bit pop,
                         output bit a_ack, output bit d_ack);
    m_start();
    m_write_byte({addr, 1'b0}, 1'b0, a_ack);
    d_ack = 1'b0;
    if (a_ack) m_write_byte(data, pop, d_ack);
    m_stop();
  endtask

  task automatic m_read(input logic [6:0] addr, output bit a_ack, output logic [7:0] d);
    m_start();
    m_write_byte({addr, 1'b1}, 1'b0, a_ack);
    d = 8'hxx;
    if (a_ack) m_read_byte(d);
    m_stop();
  endtask

  task automatic pop_one();
    rx_rd = 1'b1;
    wait_n(1);
    rx_rd = 1'b0;
    wait_n(1);
  endtask

  task automatic load_tx(input logic [7:0] b);
    tx_data = b;
    tx_load = 1'b1;
    wait_n(1);
    tx_load = 1'b0;
    model_tx  = b;
    model_txv = 1'b1;
  endtask

  task automatic drain_check(input string tag);
    while (model_q.size() > 0) begin
      n_tests++;
      if (rx_data !== model_q[0]) begin
        n_fail++;
        $display("FAIL %s_pop_data: got %h want %h", tag, rx_data, model_q[0]);
      end
      pop_one();
      void'(model_q.pop_front());
    end
    n_tests++;
    if (rx_empty !== 1'b1 || rx_level !== 4'd0) begin
      n_fail++;
      $display("FAIL %s_empty_after: got empty=%b level=%0d want 1/0", tag, rx_empty, rx_level);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_n(4);
    n_tests++; if (sda_en !== 1'b0)    begin n_fail++; $display("FAIL rst_sda_en: got %b want 0", sda_en); end
    n_tests++; if (sda_out !== 1'b1)   begin n_fail++; $display("FAIL rst_sda_out: got %b want 1", sda_out); end
    n_tests++; if (rx_empty !== 1'b1)  begin n_fail++; $display("FAIL rst_rx_empty: got %b want 1", rx_empty); end
    n_tests++; if (rx_full !== 1'b0)   begin n_fail++; $display("FAIL rst_rx_full: got %b want 0", rx_full); end
    n_tests++; if (rx_level !== 4'd0)  begin n_fail++; $display("FAIL rst_rx_level: got %0d want 0", rx_level); end
    n_tests++; if (rx_data !== 8'h00)  begin n_fail++; $display("FAIL rst_rx_data: got %h want 00", rx_data); end
    n_tests++; if (tx_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
    n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_tests++; if (addr_nack !== 1'b0) begin n_fail++; $display("FAIL rst_addr_nack: got %b want 0", addr_nack); end
    n_tests++; if (ovf !== 1'b0)       begin n_fail++; $display("FAIL rst_ovf: got %b want 0", ovf); end
    rst_n = 1'b1;
    wait_n(4);
  endtask

  task automatic test_write();
    logic [7:0] d;
    bit a_ack, d_ack;
    for (int k = 0; k < 4; k++) begin
      d = (k == 0) ? 8'hA5 : 8'($urandom);
      m_start();
      m_write_byte({7'h50, 1'b0}, 1'b0, a_ack);
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy_high: got %b want 1", busy); end
      m_write_byte(d, 1'b0, d_ack);
      m_stop();
      model_q.push_back(d);
      n_tests++; if (a_ack !== 1'b1) begin n_fail++; $display("FAIL wr_addr_ack: got %b want 1", a_ack); end
      n_tests++; if (d_ack !== 1'b1) begin n_fail++; $display("FAIL wr_data_ack: got %b want 1", d_ack); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_after_stop: got %b want 0", busy); end
      n_tests++;
      if (rx_level !== 4'(model_q.size())) begin
        n_fail++; $display("FAIL wr_level: got %0d want %0d", rx_level, model_q.size());
      end
      n_tests++;
      if (rx_data !== model_q[0]) begin
        n_fail++; $display("FAIL wr_head: got %h want %h", rx_data, model_q[0]);
      end
    end
    drain_check("wr");
  endtask

  task automatic test_addr_mismatch();
    logic [6:0] a;
    bit a_ack, d_ack;
    int n0, d0;
    m_write(7'h50, 8'h11, 1'b0, a_ack, d_ack);
    model_q.push_back(8'h11);
    for (int k = 0; k < 4; k++) begin
      if (k == 0) a = 7'h51;
      else begin
        a = 7'($urandom);
        if (a == 7'h50) a = 7'h2A;
      end
      n0 = nack_cnt;
      d0 = drive_cnt;
      m_write(a, 8'($urandom), 1'b0, a_ack, d_ack);
      n_tests++; if (a_ack !== 1'b0) begin n_fail++; $display("FAIL mm_addr_ack a=%h: got %b want 0", a, a_ack); end
      n_tests++; if (nack_cnt - n0 !== 1) begin n_fail++; $display("FAIL mm_nack_pulses a=%h: got %0d want 1", a, nack_cnt - n0); end
      n_tests++; if (drive_cnt - d0 !== 0) begin n_fail++; $display("FAIL mm_sda_driven a=%h: got %0d cycles want 0", a, drive_cnt - d0); end
      n_tests++;
      if (rx_level !== 4'(model_q.size()) || rx_data !== model_q[0]) begin
        n_fail++; $display("FAIL mm_fifo: got level=%0d head=%h want %0d/%h", rx_level, rx_data, model_q.size(), model_q[0]);
      end
    end
    drain_check("mm");
  endtask

  task automatic test_overflow();
    bit a_ack, d_ack, exp_ack;
    logic [7:0] d;
    for (int k = 0; k < 9; k++) begin
      d = (k < 8) ? 8'(k) : 8'hEE;
      exp_ack = (model_q.size() < 8);
      m_write(7'h50, d, 1'b0, a_ack, d_ack);
      if (exp_ack) model_q.push_back(d);
      else model_ovf = 1'b1;
      n_tests++;
      if (d_ack !== exp_ack) begin
        n_fail++; $display("FAIL ovf_data_ack k=%0d: got %b want %b", k, d_ack, exp_ack);
      end
    end
    n_tests++; if (ovf !== model_ovf) begin n_fail++; $display("FAIL ovf_flag: got %b want %b", ovf, model_ovf); end
    n_tests++; if (rx_full !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b want 1", rx_full); end
    n_tests++; if (rx_level !== 4'd8) begin n_fail++; $display("FAIL ovf_level: got %0d want 8", rx_level); end
    drain_check("ovf");
    n_tests++; if (ovf !== model_ovf) begin n_fail++; $display("FAIL ovf_sticky: got %b want %b", ovf, model_ovf); end
  endtask

  task automatic test_read();
    bit a_ack;
    logic [7:0] d, exp;
    for (int k = 0; k < 5; k++) begin
      if (k == 0) load_tx(8'h3C);
      else if (k > 1 && ($urandom_range(0, 1) == 1)) load_tx(8'($urandom));
      exp = model_txv ? model_tx : 8'hFF;
      m_read(7'h50, a_ack, d);
      model_txv = 1'b0;
      n_tests++; if (a_ack !== 1'b1) begin n_fail++; $display("FAIL rd_addr_ack k=%0d: got %b want 1", k, a_ack); end
      n_tests++; if (d !== exp) begin n_fail++; $display("FAIL rd_data k=%0d: got %h want %h", k, d, exp); end
      n_tests++; if (tx_valid !== model_txv) begin n_fail++; $display("FAIL rd_tx_valid k=%0d: got %b want %b", k, tx_valid, model_txv); end
    end
  endtask

  task automatic test_back_to_back();
    bit a_ack, d_ack;
    logic [7:0] d;
    for (int k = 0; k < 3; k++) begin
      d = 8'($urandom);
      m_write(7'h50, d, 1'b0, a_ack, d_ack);
      model_q.push_back(d);
    end
    d = 8'($urandom);
    m_write(7'h50, d, 1'b1, a_ack, d_ack);
    void'(model_q.pop_front());
    model_q.push_back(d);
    n_tests++; if (d_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack: got %b want 1", d_ack); end
    n_tests++; if (rx_level !== 4'd3) begin n_fail++; $display("FAIL b2b_level: got %0d want 3", rx_level); end
    drain_check("b2b");
  endtask

  task automatic test_reset_mid();
    logic r;
    bit a_ack, d_ack;
    logic [7:0] d;
    m_write(7'h50, 8'h77, 1'b0, a_ack, d_ack);
    load_tx(8'h99);
    m_start();
    for (int i = 7; i >= 0; i--) m_bit(((8'hA0 >> i) & 8'h01) != 0, 1'b0, r);
    for (int i = 0; i < 4 * Q && !sda_en; i++) @(negedge clk);
    n_tests++; if (sda_en !== 1'b1) begin n_fail++; $display("FAIL mid_ack_drive: got %b want 1", sda_en); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (sda_en !== 1'b0) begin n_fail++; $display("FAIL mid_sda_release: got %b want 0", sda_en); end
    n_tests++; if (sda_out !== 1'b1) begin n_fail++; $display("FAIL mid_sda_out: got %b want 1", sda_out); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
    n_tests++;
    if (rx_level !== 4'd0 || rx_empty !== 1'b1 || rx_data !== 8'h00) begin
      n_fail++; $display("FAIL mid_fifo: got level=%0d empty=%b data=%h want 0/1/00", rx_level, rx_empty, rx_data);
    end
    n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_tx_valid: got %b want 0", tx_valid); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL mid_ovf: got %b want 0", ovf); end
    model_q.delete();
    model_ovf = 1'b0;
    model_txv = 1'b0;
    scl = 1'b1;
    m_low = 1'b0;
    wait_n(4);
    rst_n = 1'b1;
    wait_n(4);
    d = 8'($urandom);
    m_write(7'h50, d, 1'b0, a_ack, d_ack);
    model_q.push_back(d);
    n_tests++;
    if (a_ack !== 1'b1 || d_ack !== 1'b1) begin
      n_fail++; $display("FAIL mid_after_acks: got %b/%b want 1/1", a_ack, d_ack);
    end
    drain_check("mid");
  endtask

  initial begin
    test_reset();
    test_write();
    test_addr_mismatch();
    test_overflow();
    test_read();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
